// File: rtl/uart_echo_fifo.sv
// uart_echo_fifo
//   Buffered echo engine between a uart_rx and a uart_tx. Received bytes are
//   case-transformed according to `mode`, queued in a DEPTH-entry FIFO and
//   sent back through the transmitter with a tx_start/tx_busy handshake.
//   Mode 2'b11 holds output until a terminator (EOL) byte is queued or the
//   FIFO is full. Dropped bytes set a sticky flag and a saturating counter.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   rx_ready   one-cycle strobe, rx_data valid
//   rx_data    received byte
//   mode       00 raw, 01 to-upper, 10 to-lower, 11 raw line mode
//   ovf_clr    clears overflow and ovf_count (wins over a same-cycle drop)
//   tx_busy    busy flag from uart_tx
//   tx_start   start request to uart_tx, held until tx_busy is seen
//   tx_data    byte to uart_tx, stable while tx_start is high
//   level      FIFO occupancy 0..DEPTH
//   overflow   sticky dropped-byte flag
//   ovf_count  dropped-byte count, saturating at 255
module uart_echo_fifo #(
    parameter int unsigned       DATA_W = 8,
    parameter int unsigned       DEPTH  = 16,
    parameter logic [DATA_W-1:0] EOL    = 8'h0D
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     rx_ready,
    input  logic [DATA_W-1:0]        rx_data,
    input  logic [1:0]               mode,
    input  logic                     ovf_clr,
    input  logic                     tx_busy,
    output logic                     tx_start,
    output logic [DATA_W-1:0]        tx_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [7:0]               ovf_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam logic [LW-1:0] FULL = LW'(DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam logic [1:0] M_UPPER = 2'b01;
    localparam logic [1:0] M_LOWER = 2'b10;
    localparam logic [1:0] M_LINE  = 2'b11;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [LW-1:0]     r_lines;
    logic [1:0]        r_state;

    logic [DATA_W-1:0] w_rx_xf;
    logic [DATA_W-1:0] w_head;
    logic              w_full;
    logic              w_rel;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;
    logic              w_eol_in;
    logic              w_eol_out;

    always_comb begin
        w_rx_xf = rx_data;
        case (mode)
            M_UPPER: if (rx_data >= DATA_W'(8'h61) && rx_data <= DATA_W'(8'h7A))
                         w_rx_xf = rx_data - DATA_W'(8'h20);
            M_LOWER: if (rx_data >= DATA_W'(8'h41) && rx_data <= DATA_W'(8'h5A))
                         w_rx_xf = rx_data + DATA_W'(8'h20);
            default: w_rx_xf = rx_data;
        endcase
    end

    assign w_head = r_mem[r_rd_ptr];
    assign w_full = (level == FULL);

    // Line mode releases on a queued terminator, or when full so it cannot deadlock.
    assign w_rel  = (level != '0) && ((mode != M_LINE) || (r_lines != '0) || w_full);
    assign w_pop  = (r_state == S_IDLE) && w_rel && !tx_busy;

    // A pop in the same cycle frees a slot, so a push at full is still accepted.
    assign w_push = rx_ready && (!w_full || w_pop);
    assign w_drop = rx_ready && !w_push;

    assign w_eol_in  = w_push && (w_rx_xf == EOL);
    assign w_eol_out = w_pop  && (w_head  == EOL);

    // When full with push+pop, wr_ptr == rd_ptr: the head is read before the write lands.
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= w_rx_xf;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            level    <= '0;
            r_lines  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + AW'(1);

            case ({w_push, w_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase

            case ({w_eol_in, w_eol_out})
                2'b10:   r_lines <= r_lines + LW'(1);
                2'b01:   r_lines <= r_lines - LW'(1);
                default: r_lines <= r_lines;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            ovf_count <= '0;
        end else if (ovf_clr) begin
            overflow  <= 1'b0;
            ovf_count <= '0;
        end else if (w_drop) begin
            overflow <= 1'b1;
            if (ovf_count != 8'hFF)
                ovf_count <= ovf_count + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            tx_start <= 1'b0;
            tx_data  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        tx_data  <= w_head;
                        tx_start <= 1'b1;
                        r_state  <= S_START;
                    end
                end
                S_START: begin
                    if (tx_busy) begin
                        tx_start <= 1'b0;
                        r_state  <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (!tx_busy)
                        r_state <= S_IDLE;
                end
                default: begin
                    tx_start <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_echo_fifo.sv
// tb_uart_echo_fifo
//   Directed scenarios plus a randomized phase for uart_echo_fifo. A queue-based
//   reference model tracks FIFO contents, occupancy and overflow state; a small
//   uart_tx emulator drives tx_busy with configurable latency and frame length.
module tb_uart_echo_fifo;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data = '0;
    logic [1:0] mode = 2'b00;
    logic       ovf_clr = 1'b0;
    logic       tx_busy = 1'b0;
    logic       tx_start;
    logic [7:0] tx_data;
    logic [4:0] level;
    logic       overflow;
    logic [7:0] ovf_count;

    uart_echo_fifo #(.DATA_W(8), .DEPTH(DEPTH), .EOL(8'h0D)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_ready  (rx_ready),
        .rx_data   (rx_data),
        .mode      (mode),
        .ovf_clr   (ovf_clr),
        .tx_busy   (tx_busy),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .level     (level),
        .overflow  (overflow),
        .ovf_count (ovf_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] q[$];
    logic [7:0] sent[$];
    logic [7:0] exp_q[$];
    int         ov_m = 0;
    int         cnt_m = 0;
    int         pops = 0;
    logic       prev_start = 1'b0;
    logic [7:0] prev_data = '0;

    int d_cnt = -1;
    int b_cnt = 0;
    int lat = 1;
    int blen = 8;
    bit force_busy = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] xform(input logic [7:0] b, input logic [1:0] m);
        if (m == 2'b01 && b >= 8'h61 && b <= 8'h7A) return b - 8'h20;
        if (m == 2'b10 && b >= 8'h41 && b <= 8'h5A) return b + 8'h20;
        return b;
    endfunction

    function automatic int eol_count();
        int n = 0;
        foreach (q[i]) if (q[i] == 8'h0D) n++;
        return n;
    endfunction

    task automatic step();
        logic busy_in;
        bit   rise;
        bit   rel;
        bit   drop;
        @(posedge clk);
        #1;
        busy_in = tx_busy;
        drop = 0;
        if (!rst_n) begin
            check_eq("rst_tx_start", tx_start, 0);
            check_eq("rst_tx_data", tx_data, 0);
            check_eq("rst_level", level, 0);
            check_eq("rst_overflow", overflow, 0);
            check_eq("rst_ovf_count", ovf_count, 0);
        end else begin
            rise = tx_start && !prev_start;
            if (prev_start && !busy_in) begin
                check_eq("start_hold", tx_start, 1);
                check_eq("data_hold", tx_data, prev_data);
            end
            if (prev_start && busy_in)
                check_eq("start_drop", tx_start, 0);
            if (rise) begin
                rel = (q.size() != 0) &&
                      (mode != 2'b11 || eol_count() != 0 || q.size() == DEPTH);
                check_eq("pop_released", rel, 1);
                check_eq("pop_busy_free", busy_in, 0);
                if (q.size() != 0) begin
                    check_eq("tx_data", tx_data, q[0]);
                    void'(q.pop_front());
                end
                sent.push_back(tx_data);
                pops++;
            end
            if (rx_ready) begin
                if (q.size() < DEPTH) q.push_back(xform(rx_data, mode));
                else drop = 1;
            end
            if (ovf_clr) begin
                ov_m = 0;
                cnt_m = 0;
            end else if (drop) begin
                ov_m = 1;
                if (cnt_m < 255) cnt_m++;
            end
            check_eq("level", level, q.size());
            check_eq("overflow", overflow, ov_m);
            check_eq("ovf_count", ovf_count, cnt_m);
        end
        prev_start = tx_start;
        prev_data  = tx_data;

        // uart_tx emulator
        if (force_busy) begin
            tx_busy = 1'b1;
        end else if (b_cnt > 0) begin
            b_cnt--;
            if (b_cnt == 0) tx_busy = 1'b0;
        end else if (tx_start) begin
            if (d_cnt < 0) d_cnt = lat;
            if (d_cnt <= 1) begin
                tx_busy = 1'b1;
                b_cnt = blen;
                d_cnt = -1;
            end else begin
                d_cnt--;
            end
        end

        rx_ready = 1'b0;
        ovf_clr  = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] b);
        rx_data  = b;
        rx_ready = 1'b1;
        step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        rx_ready = 1'b0;
        q.delete();
        ov_m = 0;
        cnt_m = 0;
        prev_start = 1'b0;
        d_cnt = -1;
        #1;
        check_eq("async_rst_tx_start", tx_start, 0);
        check_eq("async_rst_level", level, 0);
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (!(q.size() == 0 && !tx_start && !tx_busy && b_cnt == 0 && d_cnt < 0) && n < budget) begin
            step();
            n++;
        end
        check_eq("drain_in_budget", (n < budget), 1);
    endtask

    task automatic check_sent(input logic [7:0] exp[$]);
        check_eq("sent_count", sent.size(), exp.size());
        foreach (exp[i]) begin
            if (i < sent.size()) check_eq("sent_byte", sent[i], exp[i]);
        end
    endtask

    initial begin
        int p0;
        logic [7:0] b;

        #2;
        rst_n = 1'b0;
        #1;
        check_eq("init_rst_level", level, 0);
        repeat (3) step();
        rst_n = 1'b1;
        repeat (2) step();

        // Raw echo
        mode = 2'b00;
        sent.delete();
        push_byte(8'h41); repeat (30) step();
        push_byte(8'h62); repeat (30) step();
        push_byte(8'h0D); repeat (30) step();
        drain(500);
        exp_q = '{8'h41, 8'h62, 8'h0D};
        check_sent(exp_q);
        check_eq("raw_overflow", overflow, 0);

        // Case modes
        mode = 2'b01;
        sent.delete();
        push_byte(8'h61); repeat (20) step();
        push_byte(8'h7A); repeat (20) step();
        push_byte(8'h5B);
        drain(500);
        exp_q = '{8'h41, 8'h5A, 8'h5B};
        check_sent(exp_q);

        mode = 2'b10;
        sent.delete();
        push_byte(8'h41); push_byte(8'h5A); push_byte(8'h60);
        drain(500);
        exp_q = '{8'h61, 8'h7A, 8'h60};
        check_sent(exp_q);

        // Burst and overflow with transmitter held busy
        mode = 2'b00;
        sent.delete();
        force_busy = 1;
        tx_busy = 1'b1;
        step();
        for (int i = 0; i < 20; i++) push_byte(8'(i));
        check_eq("burst_level", level, 16);
        check_eq("burst_ovf_count", ovf_count, 4);
        check_eq("burst_overflow", overflow, 1);
        rx_data = 8'h14; rx_ready = 1'b1; ovf_clr = 1'b1;
        step();
        check_eq("clr_wins_overflow", overflow, 0);
        check_eq("clr_wins_count", ovf_count, 0);
        for (int i = 0; i < 256; i++) push_byte(8'hEE);
        check_eq("ovf_saturate", ovf_count, 255);
        force_busy = 0;
        tx_busy = 1'b0;
        drain(1000);
        exp_q.delete();
        for (int i = 0; i < 16; i++) exp_q.push_back(8'(i));
        check_sent(exp_q);
        check_eq("post_burst_overflow", overflow, 1);
        ovf_clr = 1'b1;
        step();
        check_eq("ovf_clr_flag", overflow, 0);
        check_eq("ovf_clr_count", ovf_count, 0);

        // Line mode
        mode = 2'b11;
        sent.delete();
        p0 = pops;
        push_byte(8'h48); push_byte(8'h49);
        repeat (1000) step();
        check_eq("line_hold_pops", pops - p0, 0);
        check_eq("line_hold_level", level, 2);
        push_byte(8'h0D);
        drain(500);
        exp_q = '{8'h48, 8'h49, 8'h0D};
        check_sent(exp_q);
        sent.delete();
        p0 = pops;
        for (int i = 0; i < 16; i++) push_byte(8'h30 + 8'(i));
        repeat (100) step();
        check_eq("line_full_pops", pops - p0, 1);
        check_eq("line_full_level", level, 15);
        exp_q = '{8'h30};
        check_sent(exp_q);
        mode = 2'b00;
        drain(1000);
        check_eq("line_full_total", sent.size(), 16);

        // Handshake and pointer wrap
        sent.delete();
        exp_q.delete();
        lat = 3;
        blen = 8;
        for (int i = 0; i < 40; i++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            push_byte(b);
            repeat (19) step();
        end
        drain(1000);
        check_sent(exp_q);

        // Reset while draining a long frame with 5 bytes queued
        lat = 1;
        blen = 200;
        for (int i = 0; i < 6; i++) push_byte(8'hA0 + 8'(i));
        step();
        check_eq("pre_rst_level", level, 5);
        check_eq("pre_rst_drain_start", tx_start, 0);
        check_eq("pre_rst_drain_busy", tx_busy, 1);
        do_reset();
        p0 = pops;
        repeat (400) step();
        check_eq("post_rst_no_tx", pops - p0, 0);
        check_eq("post_rst_level", level, 0);
        blen = 8;
        sent.delete();
        push_byte(8'h5A);
        drain(500);
        exp_q = '{8'h5A};
        check_sent(exp_q);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            lat  = $urandom_range(1, 3);
            blen = $urandom_range(2, 12);
            if ($urandom_range(0, 199) == 0) mode = 2'($urandom);
            if ($urandom_range(0, 99) == 0) ovf_clr = 1'b1;
            if ($urandom_range(0, 3) == 0) begin
                rx_ready = 1'b1;
                case ($urandom_range(0, 3))
                    0: rx_data = 8'h0D;
                    1: rx_data = 8'h41 + 8'($urandom_range(0, 25));
                    2: rx_data = 8'h61 + 8'($urandom_range(0, 25));
                    default: rx_data = 8'($urandom);
                endcase
            end
            step();
        end
        mode = 2'b00;
        drain(3000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_echo_fifo.md
# uart_echo_fifo

Buffered, parametrised UART echo engine placed between a `uart_rx` and a `uart_tx` instance. Received bytes enter a `DEPTH`-entry FIFO, are optionally case-converted, and are sent back through the transmitter with a full `tx_start`/`tx_busy` handshake. Incoming bytes are no longer lost while a transmission is in progress. A line mode holds output until a terminator byte arrives. Overflow is counted and flagged.

## Interface
- `DATA_W`, 8: byte width on the rx and tx data paths.
- `DEPTH`, 16: FIFO entries. Must be a power of two, ≥2.
- `EOL`, 8'h0D: terminator byte used in line mode.
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rx_ready`  in  1  one-cycle strobe from `uart_rx`: `rx_data` is valid.
- `rx_data`  in  DATA_W  received byte.
- `mode`  in  2  transform / release mode (see Operation). Sampled every cycle.
- `ovf_clr`  in  1  clears `overflow` and `ovf_count`.
- `tx_busy`  in  1  busy flag from `uart_tx`.
- `tx_start`  out  1  start request to `uart_tx`.
- `tx_data`  out  DATA_W  byte to `uart_tx`. Held stable while `tx_start` = 1.
- `level`  out  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH.
- `overflow`  out  1  sticky: a byte was dropped.
- `ovf_count`  out  8  dropped-byte count, saturating at 255.

## Operation
- Push: on `rx_ready` with `level` < DEPTH, store the transformed byte at the write pointer and increment the pointer. The transform uses the `mode` value in that cycle:
  - 00: raw.
  - 01: 0x61–0x7A → subtract 0x20.
  - 10: 0x41–0x5A → add 0x20.
  - 11: raw, line mode.
- Overflow: on `rx_ready` with `level` = DEPTH, drop the byte and set `overflow`. `ovf_count` increments by 1, saturating at 255. FIFO contents are unchanged.
- `ovf_clr` has priority over a same-cycle overflow: both clear. The dropped byte in that cycle is not counted.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. `level` is a separate counter.
  - Simultaneous push and pop: `level` is unchanged.
  - Pop is allowed at `level` = DEPTH in the same cycle as a push; the push is then accepted, not dropped.
- `lines` counter, width = width of `level`:
  - +1 on push of a byte equal to `EOL`.
  - −1 on pop of a byte equal to `EOL`.
  - Net 0 when both happen in the same cycle.
- Release condition `rel`:
  - modes 00/01/10: `level` ≠ 0.
  - mode 11: `level` ≠ 0 and (`lines` ≠ 0 or `level` = DEPTH).
- Sender FSM, states IDLE, START, DRAIN:
  - IDLE: if `rel` and `tx_busy` = 0: load `tx_data` from the FIFO head, pop, set `tx_start` = 1, go to START.
  - START: hold `tx_start` = 1 and `tx_data` until `tx_busy` = 1 is observed. Then set `tx_start` = 0 and go to DRAIN.
  - DRAIN: when `tx_busy` = 0, go to IDLE.
- A `mode` change affects only later pushes and the `rel` evaluation from that cycle on. Stored bytes are not re-transformed.

## Timing
- Reset values:
  - `tx_start` = 0, `tx_data` = 0, `level` = 0.
  - `overflow` = 0, `ovf_count` = 0.
  - pointers = 0, `lines` = 0, FSM = IDLE.
- A reset mid-frame discards the FIFO. `uart_tx` finishes its current frame on its own. The FSM leaves IDLE only once `tx_busy` = 0.
- Push latency: a byte pushed in cycle N is visible to IDLE in cycle N+1. `tx_start` rises at N+2 at the earliest.
- All outputs are registered. `level` and `overflow` update on the edge after the event.
- Minimum cost per byte: 1 cycle in IDLE, ≥1 cycle in START, plus the full `uart_tx` busy period.
- Back-to-back `rx_ready` strobes on consecutive cycles must all be accepted while `level` < DEPTH.

## Test plan
- Raw echo:
  - Stimulus: mode 00; push 0x41, 0x62, 0x0D at 115200 baud spacing.
  - Required: tx sequence 0x41, 0x62, 0x0D. `level` returns to 0. `overflow` = 0.
- Case modes:
  - Mode 01, push 0x61 0x7A 0x5B → tx 0x41 0x5A 0x5B.
  - Mode 10, push 0x41 0x5A 0x60 → tx 0x61 0x7A 0x60.
- Burst and overflow:
  - Stimulus: DEPTH = 16; hold `tx_busy` = 1; push 20 bytes 0x00..0x13 on consecutive cycles.
  - Required: `level` = 16, `ovf_count` = 4, `overflow` = 1. After `tx_busy` is released, tx sends 0x00..0x0F in order.
  - Then assert `ovf_clr` → `overflow` = 0 and `ovf_count` = 0.
- Line mode:
  - Stimulus: mode 11; push "HI" (0x48, 0x49).
  - Required: no `tx_start` for 1000 cycles. After pushing 0x0D, tx sends 0x48 0x49 0x0D and then stalls.
  - With 16 bytes pushed and no EOL, transmission starts because the FIFO is full.
- Handshake and wrap:
  - Stimulus: `tx_busy` rises 3 cycles after `tx_start`; push 40 bytes, paced so the FIFO never fills.
  - Required: `tx_start` and `tx_data` are held until `tx_busy` rises. All 40 bytes are sent in order across pointer wrap.
- Reset mid-operation:
  - Stimulus: `rst_n` low for 2 cycles while `level` = 5 and the FSM is in DRAIN.
  - Required: all outputs return to reset values. No further tx occurs until new rx bytes arrive.
